// File: rtl/wb_master_arbiter_if.sv
// Wishbone B4 bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The master modport is the initiator side; the slave modport is the target side.
interface wb_master_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter; a grant lasts for the owner's whole CYC.
// Define WB_ARB_WATCHDOG_EN to add the slave-stall watchdog (forced error after TIMEOUT).
module wb_master_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 30,
    parameter int DW      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_master_arbiter_if.slave   m0,
    wb_master_arbiter_if.slave   m1,
    wb_master_arbiter_if.master  s,
    output logic [1:0]           grant
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    logic   last;
    logic   stb_mux;
    logic   wd_fire;

    if (TIMEOUT < 1 || TIMEOUT > 65535 || AW < 1 || DW < 8 || (DW % 8) != 0) begin : g_bad_param
        $error("wb_master_arbiter: illegal parameter value");
    end

    // last=1 after reset so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.cyc && (!m1.cyc || last)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (m1.cyc) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0.cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1.cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        s.cyc   = 1'b0;
        s.we    = 1'b0;
        s.cti   = '0;
        s.bte   = '0;
        stb_mux = 1'b0;
        if (grant[0]) begin
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.sel   = m0.sel;
            s.cyc   = m0.cyc;
            s.we    = m0.we;
            s.cti   = m0.cti;
            s.bte   = m0.bte;
            stb_mux = m0.stb;
        end else if (grant[1]) begin
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.sel   = m1.sel;
            s.cyc   = m1.cyc;
            s.we    = m1.we;
            s.cti   = m1.cti;
            s.bte   = m1.bte;
            stb_mux = m1.stb;
        end
    end

    // A watchdog-terminated beat withdraws stb so the slave cannot also complete it
    assign s.stb    = stb_mux & ~wd_fire;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = grant[0] & s.ack & ~wd_fire;
    assign m1.ack   = grant[1] & s.ack & ~wd_fire;
    assign m0.err   = grant[0] & (s.err | wd_fire);
    assign m1.err   = grant[1] & (s.err | wd_fire);

`ifdef WB_ARB_WATCHDOG_EN
    localparam int            WW       = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    logic [WW-1:0] wd;

    assign wd_fire = (wd == WD_LIMIT);

    // s.cyc falls whenever ownership changes, so it also covers the state-change clear
    always_ff @(posedge clk) begin
        if (reset) begin
            wd <= '0;
        end else if (!s.cyc || !stb_mux || s.ack || s.err || wd_fire) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (TIMEOUT=8).
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_wb_master_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    int         passed = 0;
    int         total  = 0;

    wb_master_arbiter_if #(.AW(30), .DW(32)) m0_bus ();
    wb_master_arbiter_if #(.AW(30), .DW(32)) m1_bus ();
    wb_master_arbiter_if #(.AW(30), .DW(32)) s_bus ();

    wb_master_arbiter #(.TIMEOUT(8), .AW(30), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_masters();
        m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.sel = '0; m0_bus.cyc = 1'b0;
        m0_bus.stb = 1'b0; m0_bus.we = 1'b0; m0_bus.cti = '0; m0_bus.bte = '0;
        m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0; m1_bus.cyc = 1'b0;
        m1_bus.stb = 1'b0; m1_bus.we = 1'b0; m1_bus.cti = '0; m1_bus.bte = '0;
    endtask

    task automatic clear_slave();
        s_bus.dat_r = '0;
        s_bus.ack   = 1'b0;
        s_bus.err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_masters();
        clear_slave();
        next_cycle();
        next_cycle();
        sample();
        total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else passed++;
        total++; if (s_bus.cyc !== 1'b0) $display("FAIL rst_s_cyc: got %b want 0", s_bus.cyc); else passed++;
        total++; if (s_bus.stb !== 1'b0) $display("FAIL rst_s_stb: got %b want 0", s_bus.stb); else passed++;
        total++; if (m0_bus.ack !== 1'b0) $display("FAIL rst_m0_ack: got %b want 0", m0_bus.ack); else passed++;
        total++; if (m1_bus.err !== 1'b0) $display("FAIL rst_m1_err: got %b want 0", m1_bus.err); else passed++;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        next_cycle();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h10; m0_bus.sel = 4'hF;
        sample();
        total++; if (grant !== 2'b00) $display("FAIL rd_grant_lat: got %b want 00", grant); else passed++;
        total++; if (s_bus.cyc !== 1'b0) $display("FAIL rd_s_cyc_lat: got %b want 0", s_bus.cyc); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b01) $display("FAIL rd_grant: got %b want 01", grant); else passed++;
        total++; if (s_bus.cyc !== 1'b1) $display("FAIL rd_s_cyc: got %b want 1", s_bus.cyc); else passed++;
        total++; if (s_bus.adr !== 30'h10) $display("FAIL rd_s_adr: got %h want 10", s_bus.adr); else passed++;
        total++; if (m0_bus.ack !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", m0_bus.ack); else passed++;
        next_cycle();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF;
        sample();
        total++; if (m0_bus.ack !== 1'b1) $display("FAIL rd_m0_ack: got %b want 1", m0_bus.ack); else passed++;
        total++; if (m0_bus.dat_r !== 32'hDEADBEEF) $display("FAIL rd_m0_dat: got %h want deadbeef", m0_bus.dat_r); else passed++;
        total++; if (m1_bus.ack !== 1'b0) $display("FAIL rd_m1_ack: got %b want 0", m1_bus.ack); else passed++;
        next_cycle();
        clear_slave();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        sample();
        total++; if (s_bus.cyc !== 1'b0) $display("FAIL rd_s_cyc_drop: got %b want 0", s_bus.cyc); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b00) $display("FAIL rd_grant_end: got %b want 00", grant); else passed++;
    endtask

    task automatic test_round_robin();
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        next_cycle();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h10;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h20;
        next_cycle();
        sample();
        total++; if (grant !== 2'b01) $display("FAIL rr_first_grant: got %b want 01", grant); else passed++;
        total++; if (s_bus.adr !== 30'h10) $display("FAIL rr_first_adr: got %h want 10", s_bus.adr); else passed++;
        next_cycle();
        s_bus.ack = 1'b1;
        sample();
        total++; if (m0_bus.ack !== 1'b1) $display("FAIL rr_m0_ack: got %b want 1", m0_bus.ack); else passed++;
        total++; if (m1_bus.ack !== 1'b0) $display("FAIL rr_m1_held: got %b want 0", m1_bus.ack); else passed++;
        next_cycle();
        s_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        sample();
        total++; if (grant !== 2'b01) $display("FAIL rr_drop_grant: got %b want 01", grant); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b00) $display("FAIL rr_dead_cycle: got %b want 00", grant); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b10) $display("FAIL rr_second_grant: got %b want 10", grant); else passed++;
        total++; if (s_bus.adr !== 30'h20) $display("FAIL rr_second_adr: got %h want 20", s_bus.adr); else passed++;
        next_cycle();
        s_bus.ack = 1'b1;
        sample();
        total++; if (m1_bus.ack !== 1'b1) $display("FAIL rr_m1_ack: got %b want 1", m1_bus.ack); else passed++;
        next_cycle();
        s_bus.ack = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        next_cycle();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        next_cycle();
        sample();
        total++; if (grant !== 2'b01) $display("FAIL rr_alternate: got %b want 01", grant); else passed++;
        next_cycle();
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_no_preempt();
        next_cycle();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1; m1_bus.cti = 3'b010; m1_bus.adr = 30'h40;
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            s_bus.ack = 1'b1;
            m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
            if (b == 3) m1_bus.cti = 3'b111;
            sample();
            total++; if (m1_bus.ack !== 1'b1) $display("FAIL np_m1_ack beat %0d: got %b want 1", b, m1_bus.ack); else passed++;
            total++; if (m0_bus.ack !== 1'b0) $display("FAIL np_m0_ack beat %0d: got %b want 0", b, m0_bus.ack); else passed++;
            total++; if (grant !== 2'b10) $display("FAIL np_grant beat %0d: got %b want 10", b, grant); else passed++;
            if (b == 3) begin
                total++; if (s_bus.cti !== 3'b111) $display("FAIL np_cti_end: got %b want 111", s_bus.cti); else passed++;
            end
        end
        next_cycle();
        s_bus.ack = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.cti = 3'b000;
        sample();
        total++; if (grant !== 2'b10) $display("FAIL np_hold_after_drop: got %b want 10", grant); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b00) $display("FAIL np_dead_cycle: got %b want 00", grant); else passed++;
        next_cycle();
        sample();
        total++; if (grant !== 2'b01) $display("FAIL np_m0_granted: got %b want 01", grant); else passed++;
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_watchdog();
        next_cycle();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1; m1_bus.adr = 30'h55; m1_bus.dat_w = 32'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            sample();
            total++; if (m1_bus.err !== 1'b0) $display("FAIL wd_early_err cycle %0d: got %b want 0", c, m1_bus.err); else passed++;
            total++; if (s_bus.stb !== 1'b1) $display("FAIL wd_stall_stb cycle %0d: got %b want 1", c, s_bus.stb); else passed++;
        end
        next_cycle();
        sample();
`ifdef WB_ARB_WATCHDOG_EN
        total++; if (m1_bus.err !== 1'b1) $display("FAIL wd_err: got %b want 1", m1_bus.err); else passed++;
        total++; if (s_bus.stb !== 1'b0) $display("FAIL wd_stb_forced: got %b want 0", s_bus.stb); else passed++;
`else
        total++; if (m1_bus.err !== 1'b0) $display("FAIL wd_no_err: got %b want 0", m1_bus.err); else passed++;
        total++; if (s_bus.stb !== 1'b1) $display("FAIL wd_still_stalled: got %b want 1", s_bus.stb); else passed++;
`endif
        total++; if (m0_bus.err !== 1'b0) $display("FAIL wd_m0_err: got %b want 0", m0_bus.err); else passed++;
        total++; if (grant !== 2'b10) $display("FAIL wd_grant: got %b want 10", grant); else passed++;
        next_cycle();
        sample();
        total++; if (m1_bus.err !== 1'b0) $display("FAIL wd_err_one_cycle: got %b want 0", m1_bus.err); else passed++;
        total++; if (grant !== 2'b10) $display("FAIL wd_keeps_owner: got %b want 10", grant); else passed++;
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h10;
        next_cycle();
        sample();
        total++; if (grant !== 2'b01) $display("FAIL rm_pre_grant: got %b want 01", grant); else passed++;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        sample();
        total++; if (s_bus.cyc !== 1'b0) $display("FAIL rm_s_cyc: got %b want 0", s_bus.cyc); else passed++;
        total++; if (s_bus.stb !== 1'b0) $display("FAIL rm_s_stb: got %b want 0", s_bus.stb); else passed++;
        total++; if (grant !== 2'b00) $display("FAIL rm_grant: got %b want 00", grant); else passed++;
        total++; if (m0_bus.ack !== 1'b0) $display("FAIL rm_m0_ack: got %b want 0", m0_bus.ack); else passed++;
        next_cycle();
        reset = 1'b0;
        clear_masters();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h33;
        next_cycle();
        sample();
        total++; if (grant !== 2'b10) $display("FAIL rm_m1_grant: got %b want 10", grant); else passed++;
        total++; if (s_bus.cyc !== 1'b1) $display("FAIL rm_m1_s_cyc: got %b want 1", s_bus.cyc); else passed++;
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_no_preempt();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master, one-slave Wishbone arbiter in front of the USB device core's control/status Wishbone port. It lets the simulation host master (port 0) and the soft-CPU master (port 1) share the core's register space. Arbitration is round-robin, and a grant lasts for a whole bus cycle (CYC). An optional watchdog terminates slave accesses that never complete.

## Interface
Parameters:
- TIMEOUT, 255: slave stall limit in clk cycles before a forced error. Legal range 1..65535.
- AW, 30: Wishbone word-address width.
- DW, 32: Wishbone data width. SEL width is DW/8.

Ports (N = 0, 1; port 0 is the host, port 1 is the CPU):
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_adr  in  AW  master address.
- mN_dat_w  in  DW  master write data.
- mN_sel  in  DW/8  byte selects.
- mN_cyc, mN_stb, mN_we  in  1 each  master cycle, strobe and write enable.
- mN_cti, mN_bte  in  3 / 2  burst tags; passed through unchanged.
- mN_dat_r  out  DW  read data; equals s_dat_r for both masters at all times.
- mN_ack, mN_err  out  1 each  termination; driven only to the granted master, 0 otherwise.
- s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte  out  as master  the granted master's signals, all 0 when no master is granted.
- s_dat_r  in  DW; s_ack, s_err  in  1 each  slave responses.
- grant  out  2  one-hot registered grant; bit N set means master N owns the slave.

## Operation
- State machine with three states: IDLE, OWN0, OWN1.
- IDLE:
  - If only master N has mN_cyc=1, go to OWNN.
  - If both request, grant the master that is not `last`. `last` holds the index of the most recently granted master.
  - With no requests, stay in IDLE.
- OWNN:
  - The slave bus is muxed combinationally from master N.
  - s_ack and s_err pass straight through to master N.
  - When mN_cyc=0 is sampled, go to IDLE and set last←N.
- A grant is never pre-empted while its holder keeps mN_cyc high, including during burst cycles (cti=001/010).
- The non-granted master sees ack=0 and err=0 and is held off. A requester that is not granted waits at least until the owner drops cyc.
- If the slave asserts s_ack in the same cycle the owner drops cyc, the ack still reaches the owner, then the arbiter returns to IDLE.
- Watchdog (only when compiled in, see Configuration):
  - Counter `wd` of width clog2(TIMEOUT+1).
  - `wd` increments each cycle with s_cyc & s_stb & !s_ack & !s_err.
  - `wd` clears on s_ack, s_err, stb low, or any state change.
  - When wd==TIMEOUT, the next cycle asserts mN_err=1 for exactly one cycle and forces s_stb=0 in that cycle; `wd` clears.
  - The master keeps ownership until it drops cyc.
- Reset values: state=IDLE, grant=00, last=1 (so master 0 wins the first tie), wd=0. All s_* outputs, mN_ack and mN_err are 0.

## Timing
- Arbitration latency: mN_cyc rising in IDLE at edge k gives grant and s_cyc=1 after edge k+1.
- Handover: the owner drops cyc at edge k; the arbiter is in IDLE after k+1 and the next grant is visible after k+2. There is exactly one dead cycle between owners.
- Data and termination paths are combinational while granted: zero added latency from s_ack to mN_ack and from mN_stb to s_stb.
- Reset asserted mid-access: s_cyc, s_stb and grant are 0 after the reset edge. No ack or err is generated for the aborted access.
- Watchdog error: asserted in cycle TIMEOUT+1 after stall start, i.e. stb high with no response from cycle 1.

## Configuration
- WB_ARB_WATCHDOG_EN defined: the watchdog counter, forced error and TIMEOUT parameter are active.
- WB_ARB_WATCHDOG_EN undefined: no counter is synthesized. mN_err = s_err when granted, and a stalled slave holds the bus indefinitely.

## Test plan
- Single host read: m0 reads adr 0x0000_0010; slave acks after 2 cycles with 0xDEADBEEF -> s_cyc one cycle after m0_cyc, m0_ack pulse, m0_dat_r=0xDEADBEEF, grant 01 then 00.
- Simultaneous request from reset: m0 and m1 raise cyc together -> m0 granted first. After m0 drops cyc, one idle cycle, then grant=10. A second simultaneous request afterwards -> m0 granted (round-robin alternation).
- No pre-emption: m1 holds a 4-beat burst (cti=010, then 111) while m0 requests -> all 4 acks go to m1, m0_ack stays 0, and m0 is granted 2 cycles after m1 drops cyc.
- Watchdog (WB_ARB_WATCHDOG_EN, TIMEOUT=8): slave never acks an m1 write -> m1_err=1 for one cycle 9 cycles after stb rose, s_stb=0 in that cycle, m0_err=0. Without the macro -> no err, bus stays stalled.
- Reset mid-access: assert reset while m0 owns the bus with stb high -> s_cyc=0, grant=00, m0_ack=0 on the next cycle. After reset a single m1 request is granted.
